riscv_alu_if: RTL and testbench
===============================

Name: riscv_alu_if

Overview:
AHB-Lite slave wrapping a RISC-V integer ALU as a memory-mapped peripheral. The bus master writes operand A, operand B and a 4-bit operation code into registers, then reads the result from a read-only register. The block sits on the system AHB bus at base 0xE000_0000 and is selected by the external decoder through sl_HSEL.

Parameters:
None. W_BURST is taken from the codebase AHB header (value 3).

Ports:
HCLK  input  1  bus clock, all state on rising edge
HRESETn  input  1  reset, asynchronous, active-low
sl_HSEL  input  1  slave select from the bus decoder
sl_HREADY  input  1  bus-level HREADY; qualifies the address phase
sl_HTRANS  input  2  transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
sl_HBURST  input  W_BURST  burst type; accepted, ignored
sl_HSIZE  input  3  transfer size; accepted, ignored (all accesses treated as 32-bit)
sl_HADDR  input  32  byte address; only bits [3:2] are decoded
sl_HWRITE  input  1  1=write, 0=read
sl_HWDATA  input  32  write data, valid in the data phase
out_sl_HREADY  output  1  slave ready; constant 1 (zero wait states)
out_sl_HRESP  output  2  response; constant 2'b00 (OKAY)
out_sl_HRDATA  output  32  read data, valid in the data phase

Behaviour:
- Register map (offset = HADDR[3:2]):
  - 0x00 ALU_OP: 4 bits, R/W.
  - 0x04 ALU_A: 32 bits, R/W.
  - 0x08 ALU_B: 32 bits, R/W.
  - 0x0C ALU_P: 32 bits, read-only; writes are ignored.
- Reset (HRESETn=0, asynchronous):
  - ALU_OP, ALU_A, ALU_B and all address-phase capture registers clear to 0.
  - out_sl_HRDATA=0 while no read data phase is active.
- Address phase:
  - A transfer is valid when sl_HSEL & sl_HREADY & sl_HTRANS[1].
  - On a valid transfer, register a valid flag, sl_HWRITE and sl_HADDR[3:2] at the rising edge of HCLK.
  - IDLE and BUSY transfers clear the valid flag and cause no access.
- Write data phase:
  - On the edge after the address phase, when valid & write, load sl_HWDATA into the addressed register.
  - ALU_OP takes HWDATA[3:0]; upper bits are discarded.
- Read data phase:
  - When valid & read, out_sl_HRDATA is driven combinationally from the addressed register during the cycle after the address phase.
  - ALU_OP reads zero-extended; ALU_P reads the current combinational ALU result.
  - Outside a read data phase out_sl_HRDATA=0.
- Back-to-back transfers:
  - Supported with zero wait states. A write data phase overlapping the next address phase is legal.
  - A read issued immediately after writing an operand returns the result using the updated operand, because the write commits at the edge that begins the read data phase.
- ALU_P is purely combinational from ALU_OP, ALU_A and ALU_B. There is no start bit, so the result is valid one cycle after the last write.
- Operation encodings (riscv_defines ALU_* must match):
  - ADD=0: A+B, mod 2^32.
  - SLL=1: A<<B[4:0].
  - SLT=2: signed A<B gives 1, else 0.
  - SLTU=3: unsigned A<B gives 1, else 0.
  - XOR=4: A^B.
  - SRL=5: logical A>>B[4:0].
  - OR=6: A|B.
  - AND=7: A&B.
  - SUB=8: A-B, mod 2^32.
  - SRA=13: arithmetic A>>>B[4:0].
  - Any other code gives 0.
- Arithmetic rules:
  - Overflow wraps and no flags are produced.
  - Shift amounts use only B[4:0]; B[31:5] are ignored.
- Reset asserted mid-transfer aborts the pending data phase. No register is written and HRDATA returns to 0.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08, 0x0C -> all return 0x0000_0000 (ADD 0+0); HREADY=1 and HRESP=00 throughout.
- Write A=0x0, B=0x1, OP=SLT(2), read 0x0C -> 0x0000_0001; readback of 0x04/0x08/0x00 -> 0x0, 0x1, 0x2.
- Write A=0x8, B=0x6, OP=ADD(0), read 0x0C -> 0x0000_000E; then OP=SUB(8) -> 0x0000_0002; then A=0x5, B=0x7 -> 0xFFFF_FFFE.
- A=0xFFFF_FFFF, B=0x1: SLT -> 0x1, SLTU -> 0x0. A=0x8000_0000, B=0x24: SRA -> 0xF800_0000, SRL -> 0x0800_0000, SLL -> 0x0 (shift amount 4).
- Write 0x1234_5678 to 0x0C, then read 0x0C -> unchanged ALU result. Write 0xFFFF_FFF7 to 0x00 -> OP reads 0x7 (AND). Unused code 0xF -> result 0.
- Back-to-back NONSEQ write A=0x3 immediately followed by a read of 0x0C with OP=ADD, B=0x4 -> 0x0000_0007. Assert HRESETn low mid-data-phase of a write -> register not updated and all registers read 0.

Source files
------------

// File: rtl/riscv_alu_if.sv
// AHB-Lite slave exposing a RISC-V integer ALU as four memory-mapped words:
// OP (0x0), A (0x4), B (0x8) and the read-only combinational result P (0xC).
module riscv_alu_if #(
  localparam int W_BURST = 3
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               sl_HSEL,
  input  logic               sl_HREADY,
  input  logic [1:0]         sl_HTRANS,
  input  logic [W_BURST-1:0] sl_HBURST,
  input  logic [2:0]         sl_HSIZE,
  input  logic [31:0]        sl_HADDR,
  input  logic               sl_HWRITE,
  input  logic [31:0]        sl_HWDATA,
  output logic               out_sl_HREADY,
  output logic [1:0]         out_sl_HRESP,
  output logic [31:0]        out_sl_HRDATA
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLL  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SUB  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd13;

  localparam logic [1:0] ADDR_OP = 2'd0;
  localparam logic [1:0] ADDR_A  = 2'd1;
  localparam logic [1:0] ADDR_B  = 2'd2;
  localparam logic [1:0] ADDR_P  = 2'd3;

  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_valid;
  logic        r_write;
  logic [1:0]  r_addr;

  logic        w_xfer;
  logic [4:0]  w_shamt;
  logic [31:0] w_result;
  logic        w_unused;

  // Burst, size and the undecoded address bits have no effect on this slave.
  assign w_unused = ^{sl_HBURST, sl_HSIZE, sl_HADDR[31:4], sl_HADDR[1:0], sl_HTRANS[0]};

  assign w_xfer  = sl_HSEL & sl_HREADY & sl_HTRANS[1];
  assign w_shamt = r_b[4:0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
    end else begin
      if (r_valid && r_write) begin
        case (r_addr)
          ADDR_OP: r_op <= sl_HWDATA[3:0];
          ADDR_A:  r_a  <= sl_HWDATA;
          ADDR_B:  r_b  <= sl_HWDATA;
          default: ;
        endcase
      end
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_write <= sl_HWRITE;
        r_addr  <= sl_HADDR[3:2];
      end
    end
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      ALU_ADD:  w_result = r_a + r_b;
      ALU_SLL:  w_result = r_a << w_shamt;
      ALU_SLT:  w_result = {31'd0, $signed(r_a) < $signed(r_b)};
      ALU_SLTU: w_result = {31'd0, r_a < r_b};
      ALU_XOR:  w_result = r_a ^ r_b;
      ALU_SRL:  w_result = r_a >> w_shamt;
      ALU_OR:   w_result = r_a | r_b;
      ALU_AND:  w_result = r_a & r_b;
      ALU_SUB:  w_result = r_a - r_b;
      ALU_SRA:  w_result = $unsigned($signed(r_a) >>> w_shamt);
      default:  w_result = '0;
    endcase
  end

  always_comb begin
    out_sl_HRDATA = '0;
    if (r_valid && !r_write) begin
      case (r_addr)
        ADDR_OP: out_sl_HRDATA = {28'd0, r_op};
        ADDR_A:  out_sl_HRDATA = r_a;
        ADDR_B:  out_sl_HRDATA = r_b;
        ADDR_P:  out_sl_HRDATA = w_result;
        default: out_sl_HRDATA = '0;
      endcase
    end
  end

  assign out_sl_HREADY = 1'b1;
  assign out_sl_HRESP  = 2'b00;

endmodule

// File: tb/tb_riscv_alu_if.sv
// Directed bench for riscv_alu_if: single and back-to-back AHB transfers
// against hand-computed ALU results.
module tb_riscv_alu_if;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        sl_HSEL;
  logic        sl_HREADY;
  logic [1:0]  sl_HTRANS;
  logic [2:0]  sl_HBURST;
  logic [2:0]  sl_HSIZE;
  logic [31:0] sl_HADDR;
  logic        sl_HWRITE;
  logic [31:0] sl_HWDATA;
  logic        out_sl_HREADY;
  logic [1:0]  out_sl_HRESP;
  logic [31:0] out_sl_HRDATA;

  int n_checks = 0;
  int n_errors = 0;

  riscv_alu_if dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .sl_HSEL       (sl_HSEL),
    .sl_HREADY     (sl_HREADY),
    .sl_HTRANS     (sl_HTRANS),
    .sl_HBURST     (sl_HBURST),
    .sl_HSIZE      (sl_HSIZE),
    .sl_HADDR      (sl_HADDR),
    .sl_HWRITE     (sl_HWRITE),
    .sl_HWDATA     (sl_HWDATA),
    .out_sl_HREADY (out_sl_HREADY),
    .out_sl_HRESP  (out_sl_HRESP),
    .out_sl_HRDATA (out_sl_HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr);
    sl_HSEL   = 1'b1;
    sl_HTRANS = 2'b10;
    sl_HWRITE = wr;
    sl_HADDR  = 32'hE000_0000 | addr;
  endtask

  task automatic go_idle();
    sl_HSEL   = 1'b0;
    sl_HTRANS = 2'b00;
    sl_HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    addr_phase(1'b1, addr);
    step();
    go_idle();
    sl_HWDATA = data;
    step();
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    addr_phase(1'b0, addr);
    step();
    go_idle();
    data = out_sl_HRDATA;
    step();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(addr, d);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    HRESETn   = 1'b0;
    sl_HREADY = 1'b1;
    sl_HBURST = 3'b000;
    sl_HSIZE  = 3'b010;
    sl_HWDATA = '0;
    sl_HADDR  = '0;
    go_idle();
    repeat (3) step();
    chk("rdata_in_reset", out_sl_HRDATA, 32'h0);
    HRESETn = 1'b1;
    step();

    rd_chk("reset_op", 32'h0, 32'h0);
    rd_chk("reset_a",  32'h4, 32'h0);
    rd_chk("reset_b",  32'h8, 32'h0);
    rd_chk("reset_p",  32'hC, 32'h0);
    chk("hready", {31'd0, out_sl_HREADY}, 32'h1);
    chk("hresp",  {30'd0, out_sl_HRESP},  32'h0);

    ahb_write(32'h4, 32'h0);
    ahb_write(32'h8, 32'h1);
    ahb_write(32'h0, 32'h2);
    rd_chk("slt_0_1", 32'hC, 32'h1);
    rd_chk("rb_a",    32'h4, 32'h0);
    rd_chk("rb_b",    32'h8, 32'h1);
    rd_chk("rb_op",   32'h0, 32'h2);
    chk("rdata_idle", out_sl_HRDATA, 32'h0);

    ahb_write(32'h4, 32'h8);
    ahb_write(32'h8, 32'h6);
    ahb_write(32'h0, 32'h0);
    rd_chk("add_8_6", 32'hC, 32'hE);
    ahb_write(32'h0, 32'h8);
    rd_chk("sub_8_6", 32'hC, 32'h2);
    ahb_write(32'h4, 32'h5);
    ahb_write(32'h8, 32'h7);
    rd_chk("sub_5_7", 32'hC, 32'hFFFF_FFFE);

    ahb_write(32'h4, 32'hFFFF_FFFF);
    ahb_write(32'h8, 32'h1);
    ahb_write(32'h0, 32'h2);
    rd_chk("slt_m1_1", 32'hC, 32'h1);
    ahb_write(32'h0, 32'h3);
    rd_chk("sltu_m1_1", 32'hC, 32'h0);

    ahb_write(32'h4, 32'h8000_0000);
    ahb_write(32'h8, 32'h24);
    ahb_write(32'h0, 32'hD);
    rd_chk("sra", 32'hC, 32'hF800_0000);
    ahb_write(32'h0, 32'h5);
    rd_chk("srl", 32'hC, 32'h0800_0000);
    ahb_write(32'h0, 32'h1);
    rd_chk("sll", 32'hC, 32'h0);
    ahb_write(32'h4, 32'h0000_0003);
    rd_chk("sll_3", 32'hC, 32'h30);

    ahb_write(32'h4, 32'hF0F0_00FF);
    ahb_write(32'h8, 32'h0FF0_0F0F);
    ahb_write(32'h0, 32'h4);
    rd_chk("xor", 32'hC, 32'hFF00_0FF0);
    ahb_write(32'h0, 32'h6);
    rd_chk("or",  32'hC, 32'hFFF0_0FFF);
    ahb_write(32'h0, 32'h7);
    rd_chk("and", 32'hC, 32'h00F0_000F);

    ahb_write(32'hC, 32'h1234_5678);
    rd_chk("p_readonly", 32'hC, 32'h00F0_000F);
    ahb_write(32'h0, 32'hFFFF_FFF7);
    rd_chk("op_trunc", 32'h0, 32'h7);
    ahb_write(32'h0, 32'hF);
    rd_chk("op_unused", 32'hC, 32'h0);
    ahb_write(32'h0, 32'h9);
    rd_chk("op_9_unused", 32'hC, 32'h0);

    // BUSY and unselected transfers must not write
    sl_HSEL = 1'b1; sl_HTRANS = 2'b01; sl_HWRITE = 1'b1; sl_HADDR = 32'hE000_0004;
    step();
    go_idle(); sl_HWDATA = 32'hDEAD_BEEF;
    step();
    rd_chk("busy_no_write", 32'h4, 32'hF0F0_00FF);
    sl_HSEL = 1'b0; sl_HTRANS = 2'b10; sl_HWRITE = 1'b1; sl_HADDR = 32'hE000_0004;
    step();
    go_idle(); sl_HWDATA = 32'hDEAD_BEEF;
    step();
    rd_chk("nosel_no_write", 32'h4, 32'hF0F0_00FF);

    // back-to-back: write A then read P in the overlapping cycle
    ahb_write(32'h0, 32'h0);
    ahb_write(32'h8, 32'h4);
    addr_phase(1'b1, 32'h4);
    step();
    sl_HWDATA = 32'h3;
    addr_phase(1'b0, 32'hC);
    step();
    go_idle();
    chk("b2b_add", out_sl_HRDATA, 32'h7);
    step();
    rd_chk("b2b_a", 32'h4, 32'h3);

    // reset during a write data phase
    addr_phase(1'b1, 32'h4);
    step();
    go_idle();
    sl_HWDATA = 32'hCAFE_F00D;
    #1 HRESETn = 1'b0;
    step();
    chk("rst_rdata", out_sl_HRDATA, 32'h0);
    HRESETn = 1'b1;
    step();
    rd_chk("rst_a", 32'h4, 32'h0);
    rd_chk("rst_b", 32'h8, 32'h0);
    rd_chk("rst_op", 32'h0, 32'h0);
    rd_chk("rst_p", 32'hC, 32'h0);
    chk("hready_end", {31'd0, out_sl_HREADY}, 32'h1);
    chk("hresp_end",  {30'd0, out_sl_HRESP},  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
